// File: rtl/mul.sv
// Reduced-precision floating-point multiplier: 1-bit sign, 8-bit exponent (bias 127),
// MAN-bit mantissa. Product is computed combinationally and registered into ret.
module mul #(
    parameter int unsigned MAN = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [MAN+8:0] a,
    input  logic [MAN+8:0] b,
    output logic [MAN+8:0] ret
);

    localparam int unsigned PW = 2 * MAN + 2;

    logic             sa, sb, s;
    logic [7:0]       ea, eb;
    logic [MAN-1:0]   fa, fb;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    logic [PW-1:0]    prod;
    logic             norm;
    logic [MAN-1:0]   mant_pre;
    logic             guard, sticky, round_up, carry;
    logic [MAN-1:0]   mant_rnd;
    logic signed [9:0] exp_sum, exp_fin;

    logic [MAN+8:0]   ret_d;

    always_comb begin
        sa = a[MAN+8];
        sb = b[MAN+8];
        ea = a[MAN+7:MAN];
        eb = b[MAN+7:MAN];
        fa = a[MAN-1:0];
        fb = b[MAN-1:0];
        s  = sa ^ sb;

        // Subnormal operands are treated as zero.
        a_zero = (ea == 8'h00);
        b_zero = (eb == 8'h00);
        a_inf  = (ea == 8'hFF) && (fa == '0);
        b_inf  = (eb == 8'hFF) && (fb == '0);
        a_nan  = (ea == 8'hFF) && (fa != '0);
        b_nan  = (eb == 8'hFF) && (fb != '0);

        prod    = {{(MAN+1){1'b0}}, 1'b1, fa} * {{(MAN+1){1'b0}}, 1'b1, fb};
        exp_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
        norm    = prod[PW-1];

        // Mantissa excludes the hidden bit, which is always 1 after normalization.
        if (norm) begin
            mant_pre = prod[2*MAN:MAN+1];
            guard    = prod[MAN];
            sticky   = |prod[MAN-1:0];
        end else begin
            mant_pre = prod[2*MAN-1:MAN];
            guard    = prod[MAN-1];
            sticky   = |prod[MAN-2:0];
        end

        round_up = guard & (sticky | mant_pre[0]);
        // All-ones mantissa plus one wraps to zero and bumps the exponent.
        carry    = round_up & (&mant_pre);
        mant_rnd = mant_pre + {{(MAN-1){1'b0}}, round_up};
        exp_fin  = exp_sum + $signed({9'b0, norm}) + $signed({9'b0, carry});

        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            ret_d = {1'b0, 8'hFF, 1'b1, {(MAN-1){1'b0}}};
        end else if (a_inf || b_inf) begin
            ret_d = {s, 8'hFF, {MAN{1'b0}}};
        end else if (a_zero || b_zero) begin
            ret_d = {s, 8'h00, {MAN{1'b0}}};
        end else if (exp_fin >= 10'sd255) begin
            ret_d = {s, 8'hFF, {MAN{1'b0}}};
        end else if (exp_fin <= 10'sd0) begin
            ret_d = {s, 8'h00, {MAN{1'b0}}};
        end else begin
            ret_d = {s, exp_fin[7:0], mant_rnd};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ret <= '0;
        end else begin
            ret <= ret_d;
        end
    end

endmodule

// File: tb/tb_mul.sv
// Scoreboard bench for mul at MAN=10, 9 and 7: directed spec vectors plus random
// operands checked against an integer reference model.
module tb_mul;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [18:0] a10, b10, ret10;
    logic [17:0] a9, b9, ret9;
    logic [15:0] a7, b7, ret7;

    int tests = 0;
    int fails = 0;

    bit [31:0] q10[$];
    bit [31:0] q9[$];
    bit [31:0] q7[$];

    mul #(.MAN(10)) u_mul10 (.clk(clk), .rst_n(rst_n), .a(a10), .b(b10), .ret(ret10));
    mul #(.MAN(9))  u_mul9  (.clk(clk), .rst_n(rst_n), .a(a9),  .b(b9),  .ret(ret9));
    mul #(.MAN(7))  u_mul7  (.clk(clk), .rst_n(rst_n), .a(a7),  .b(b7),  .ret(ret7));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end
    endtask

    // Exact integer product of significands, rounded to man+1 significant bits (RNE).
    function automatic bit [31:0] ref_mul(input int man, input bit [31:0] x, input bit [31:0] y);
        longint one, fx, fy, p, q, rem, half, r;
        int     ex, ey, e, n, sh;
        bit     s;
        one = longint'(1) << man;
        s   = x[man+8] ^ y[man+8];
        ex  = int'((x >> man) & 32'hFF);
        ey  = int'((y >> man) & 32'hFF);
        fx  = longint'(x) & (one - 1);
        fy  = longint'(y) & (one - 1);
        if ((ex == 255 && fx != 0) || (ey == 255 && fy != 0) ||
            (ex == 255 && ey == 0) || (ey == 255 && ex == 0)) begin
            r = (longint'(255) << man) | (longint'(1) << (man - 1));
        end else if (ex == 255 || ey == 255) begin
            r = (longint'(s) << (man + 8)) | (longint'(255) << man);
        end else if (ex == 0 || ey == 0) begin
            r = longint'(s) << (man + 8);
        end else begin
            p = (one + fx) * (one + fy);
            n = 0;
            while ((p >> n) != 0) n++;
            sh   = n - (man + 1);
            q    = p >> sh;
            rem  = p - (q << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && q[0])) q++;
            if (q == 2 * one) begin
                q = q >> 1;
                n++;
            end
            e = ex + ey - 127 + (n - (2 * man + 1));
            if (e >= 255)     r = (longint'(s) << (man + 8)) | (longint'(255) << man);
            else if (e <= 0)  r = longint'(s) << (man + 8);
            else              r = (longint'(s) << (man + 8)) | (longint'(e) << man) | (q - one);
        end
        return r[31:0];
    endfunction

    function automatic bit [31:0] rnd_op(input int man);
        bit [31:0] sg, ex, fr;
        int        k;
        sg = 32'($urandom_range(0, 1));
        fr = $urandom & ((32'd1 << man) - 1);
        k  = int'($urandom_range(0, 9));
        if (k == 0)      ex = 0;
        else if (k == 1) begin
            ex = 255;
            if ($urandom_range(0, 1) == 0) fr = 0;
        end
        else if (k < 6)  ex = 32'($urandom_range(100, 155));
        else             ex = 32'($urandom_range(1, 254));
        return (sg << (man + 8)) | (ex << man) | fr;
    endfunction

    task automatic issue(input bit [31:0] x10, input bit [31:0] y10, input bit [31:0] e10,
                         input bit [31:0] x9, input bit [31:0] y9, input bit [31:0] e9,
                         input bit [31:0] x7, input bit [31:0] y7, input bit [31:0] e7);
        a10 = x10[18:0];
        b10 = y10[18:0];
        a9  = x9[17:0];
        b9  = y9[17:0];
        a7  = x7[15:0];
        b7  = y7[15:0];
        q10.push_back(e10);
        q9.push_back(e9);
        q7.push_back(e7);
    endtask

    task automatic issue_rnd();
        bit [31:0] x10, y10, x9, y9, x7, y7;
        x10 = rnd_op(10); y10 = rnd_op(10);
        x9  = rnd_op(9);  y9  = rnd_op(9);
        x7  = rnd_op(7);  y7  = rnd_op(7);
        issue(x10, y10, ref_mul(10, x10, y10), x9, y9, ref_mul(9, x9, y9),
              x7, y7, ref_mul(7, x7, y7));
    endtask

    // Monitor: ret is a registered output, one result per cycle.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            check("rst10", 32'(ret10), 32'h0);
            check("rst9", 32'(ret9), 32'h0);
            check("rst7", 32'(ret7), 32'h0);
        end else begin
            if (q10.size() > 0) check("mul10", 32'(ret10), q10.pop_front());
            if (q9.size() > 0)  check("mul9", 32'(ret9), q9.pop_front());
            if (q7.size() > 0)  check("mul7", 32'(ret7), q7.pop_front());
        end
    end

    bit [31:0] dir10 [10][3] = '{
        '{32'h20000, 32'h20200, 32'h20600},
        '{32'h1FE00, 32'h1FE00, 32'h20080},
        '{32'h60000, 32'h20200, 32'h60600},
        '{32'h60000, 32'h00000, 32'h40000},
        '{32'h00001, 32'h20000, 32'h00000},
        '{32'h3FC00, 32'h00000, 32'h3FE00},
        '{32'h3FC00, 32'h60000, 32'h7FC00},
        '{32'h3FC01, 32'h1FC00, 32'h3FE00},
        '{32'h3FBFF, 32'h20000, 32'h3FC00},
        '{32'h06C00, 32'h06C00, 32'h00000}
    };
    bit [31:0] dir7 [2][3] = '{
        '{32'h3FC0, 32'h3F81, 32'h3FC2},
        '{32'h3FFF, 32'h3FFF, 32'h407E}
    };

    initial begin
        bit [31:0] x9, y9, e9, x7, y7, e7;
        rst_n = 1'b0;
        a10 = '0; b10 = '0; a9 = '0; b9 = '0; a7 = '0; b7 = '0;
        #1;
        check("rst_init10", 32'(ret10), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            if (i == 0) begin
                x9 = 32'h10000; y9 = 32'h10100; e9 = 32'h10300;
            end else begin
                x9 = rnd_op(9); y9 = rnd_op(9); e9 = ref_mul(9, x9, y9);
            end
            if (i < 2) begin
                x7 = dir7[i][0]; y7 = dir7[i][1]; e7 = dir7[i][2];
            end else begin
                x7 = rnd_op(7); y7 = rnd_op(7); e7 = ref_mul(7, x7, y7);
            end
            issue(dir10[i][0], dir10[i][1], dir10[i][2], x9, y9, e9, x7, y7, e7);
            @(negedge clk);
        end

        for (int i = 0; i < 400; i++) begin
            issue_rnd();
            @(negedge clk);
        end

        // Mid-stream reset: in-flight 2.0*2.0 is discarded, ret clears without a clock edge.
        a10 = 19'h20000; b10 = 19'h20000;
        a9  = 18'h10000; b9  = 18'h10000;
        a7  = 16'h4000;  b7  = 16'h4000;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async10", 32'(ret10), 32'h0);
        check("rst_async9", 32'(ret9), 32'h0);
        check("rst_async7", 32'(ret7), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        issue(32'h20000, 32'h20000, 32'h20400, 32'h10000, 32'h10000, 32'h10200,
              32'h4000, 32'h4000, 32'h4080);
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            issue_rnd();
            @(negedge clk);
        end

        for (int k = 0; k < 5 && (q10.size() + q9.size() + q7.size()) != 0; k++) begin
            @(negedge clk);
        end
        check("drain", 32'(q10.size() + q9.size() + q7.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
